// File: rtl/multi_mode_ff_bank_if.sv
// multi_mode_ff_bank_if
//   Bus bundle for the multi-mode flip-flop bank. The master side (the
//   stimulus or parent logic) drives the control and data inputs. The slave
//   side (the bank) returns the stored state and the status flags.
//
//   Signals (WIDTH = number of channels):
//     en       1        global clock enable, 0 = all channels hold
//     clr      1        synchronous clear of q to the bank's reset value
//     mode     2*WIDTH  per-channel mode, channel i uses mode[2i+1:2i]
//                       00 SR, 01 D, 10 T, 11 JK
//     a        WIDTH    primary input per channel  (S / D / T / J)
//     b        WIDTH    secondary input per channel (R / - / - / K)
//     err_clr  1        synchronous clear of the sticky err flags
//     q        WIDTH    stored state
//     qbar     WIDTH    complement of q
//     err      WIDTH    sticky flag: channel saw SR 11 while updating
//     chg      WIDTH    one-cycle pulse: q changed on the previous edge
interface multi_mode_ff_bank_if #(
  parameter int WIDTH = 8
);
  logic                 en;
  logic                 clr;
  logic [2*WIDTH-1:0]   mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 err_clr;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     qbar;
  logic [WIDTH-1:0]     err;
  logic [WIDTH-1:0]     chg;

  modport master (
    output en, clr, mode, a, b, err_clr,
    input  q, qbar, err, chg
  );

  modport slave (
    input  en, clr, mode, a, b, err_clr,
    output q, qbar, err, chg
  );
endinterface

// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank
//   Bank of WIDTH independent single-bit storage channels. On each clock
//   edge, every channel behaves as an SR, D, T or JK flip-flop, as selected
//   by its own 2-bit mode field. The bank shares a clock enable, a
//   synchronous clear to RESET_VAL, and a synchronous clear for the sticky
//   illegal-SR error flags.
//
//   Ports:
//     clk    in   clock, all state updates on the rising edge
//     rst_n  in   asynchronous active-low reset
//     bus    if   slave side of multi_mode_ff_bank_if
//                 (en, clr, mode, a, b, err_clr -> q, qbar, err, chg)
module multi_mode_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multi_mode_ff_bank_if.slave   bus
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_D  = 2'b01;
  localparam logic [1:0] MODE_T  = 2'b10;
  localparam logic [1:0] MODE_JK = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_err;
  logic [WIDTH-1:0] r_chg;

  logic [WIDTH-1:0] w_qNext;
  logic [WIDTH-1:0] w_errSet;

  // Next-state for every channel. The priority is as follows: clr, then
  // hold when disabled, then the per-channel mode function. An illegal SR
  // input is only flagged when the channel is actually updating. For this
  // reason, clr and en=0 both suppress err setting.
  always_comb begin
    w_qNext  = r_q;
    w_errSet = '0;
    if (bus.clr) begin
      w_qNext = RESET_VAL;
    end else if (bus.en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case (bus.mode[2*i +: 2])
          MODE_SR: begin
            case ({bus.a[i], bus.b[i]})
              2'b01:   w_qNext[i]  = 1'b0;
              2'b10:   w_qNext[i]  = 1'b1;
              2'b11:   w_errSet[i] = 1'b1;
              default: w_qNext[i]  = r_q[i];
            endcase
          end
          MODE_D: begin
            w_qNext[i] = bus.a[i];
          end
          MODE_T: begin
            w_qNext[i] = r_q[i] ^ bus.a[i];
          end
          MODE_JK: begin
            case ({bus.a[i], bus.b[i]})
              2'b01:   w_qNext[i] = 1'b0;
              2'b10:   w_qNext[i] = 1'b1;
              2'b11:   w_qNext[i] = ~r_q[i];
              default: w_qNext[i] = r_q[i];
            endcase
          end
          default: w_qNext[i] = r_q[i];
        endcase
      end
    end
  end

  // State registers. chg compares the value being loaded against the
  // current q, so that the change pulse lines up with the new q. In the
  // err update, a new set is ORed in after the clear. As a result, a set
  // and an err_clr on the same edge leave the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= RESET_VAL;
      r_err <= '0;
      r_chg <= '0;
    end else begin
      r_q   <= w_qNext;
      r_chg <= w_qNext ^ r_q;
      r_err <= (r_err & ~{WIDTH{bus.err_clr}}) | w_errSet;
    end
  end

  assign bus.q    = r_q;
  assign bus.qbar = ~r_q;
  assign bus.err  = r_err;
  assign bus.chg  = r_chg;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// tb_multi_mode_ff_bank
//   Directed bench for the multi-mode flip-flop bank, with WIDTH=4 and
//   RESET_VAL=4'b0101. A table of {inputs, expected q/err/chg} records is
//   applied one edge at a time. Each record starts from the state left by the
//   record before it. Hand-written sequences cover the reset behaviour while
//   idle and in the middle of a toggle run.
module tb_multi_mode_ff_bank;

  localparam int         WIDTH = 4;
  localparam logic [3:0] RVAL  = 4'b0101;

  logic clk;
  logic rst_n;

  int compareCount  = 0;
  int mismatchCount = 0;

  multi_mode_ff_bank_if #(.WIDTH(WIDTH)) bus ();

  multi_mode_ff_bank #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RVAL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       en;
    logic       clr;
    logic       errClr;
    logic [7:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] expQ;
    logic [3:0] expErr;
    logic [3:0] expChg;
  } vecT;

  localparam int NVEC = 19;
  vecT vecs [NVEC];

  // Compare all four outputs against the expected state. qbar is always
  // expected to be the complement of the expected q.
  task automatic checkOutput(input string tag, input logic [3:0] expQ,
                             input logic [3:0] expErr, input logic [3:0] expChg);
    compareCount++;
    if (bus.q !== expQ) begin
      mismatchCount++;
      $display("[TB] FAIL %s q: got %b expected %b", tag, bus.q, expQ);
    end
    compareCount++;
    if (bus.qbar !== ~expQ) begin
      mismatchCount++;
      $display("[TB] FAIL %s qbar: got %b expected %b", tag, bus.qbar, ~expQ);
    end
    compareCount++;
    if (bus.err !== expErr) begin
      mismatchCount++;
      $display("[TB] FAIL %s err: got %b expected %b", tag, bus.err, expErr);
    end
    compareCount++;
    if (bus.chg !== expChg) begin
      mismatchCount++;
      $display("[TB] FAIL %s chg: got %b expected %b", tag, bus.chg, expChg);
    end
  endtask

  // Drive one set of inputs at the falling edge. Then advance past the
  // following rising edge.
  task automatic applyStimulus(input logic en, input logic clr, input logic errClr,
                               input logic [7:0] mode, input logic [3:0] a,
                               input logic [3:0] b);
    @(negedge clk);
    bus.en      = en;
    bus.clr     = clr;
    bus.err_clr = errClr;
    bus.mode    = mode;
    bus.a       = a;
    bus.b       = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          en    clr   eclr  mode          a        b        q        err      chg
    // mixed modes {JK,T,D,SR} from 0101
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'b11100100, 4'b1111, 4'b0000, 4'b1011, 4'b0000, 4'b1110};
    // all D back to 0101
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'b01010101, 4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b1110};
    // illegal SR on all channels: hold and flag
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'b00000000, 4'b1111, 4'b1111, 4'b0101, 4'b1111, 4'b0000};
    // err_clr together with a fresh set: set wins
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'b00000000, 4'b1111, 4'b1111, 4'b0101, 4'b1111, 4'b0000};
    // err_clr with SR hold inputs clears
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'b00000000, 4'b0000, 4'b0000, 4'b0101, 4'b0000, 4'b0000};
    // JK toggle run, four edges
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'b11111111, 4'b1111, 4'b1111, 4'b1010, 4'b0000, 4'b1111};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'b11111111, 4'b1111, 4'b1111, 4'b0101, 4'b0000, 4'b1111};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'b11111111, 4'b1111, 4'b1111, 4'b1010, 4'b0000, 4'b1111};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'b11111111, 4'b1111, 4'b1111, 4'b0101, 4'b0000, 4'b1111};
    // load 1111, then clr with en=0 and SR 11: clear wins, no err
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 8'b01010101, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1010};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'b00000000, 4'b1111, 4'b1111, 4'b0101, 4'b0000, 4'b1010};
    // load 1111, then clr with en=1 and T toggles: clear wins
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'b01010101, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1010};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 8'b10101010, 4'b1111, 4'b0000, 4'b0101, 4'b0000, 4'b1010};
    // en=0 with SR 11: hold and no err
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'b00000000, 4'b1111, 4'b1111, 4'b0101, 4'b0000, 4'b0000};
    // SR per channel: ch3 set, ch0 reset, ch1/ch2 hold
    vecs[14] = '{1'b1, 1'b0, 1'b0, 8'b00000000, 4'b1000, 4'b0001, 4'b1100, 4'b0000, 4'b1001};
    // JK per channel: ch0 11, ch1 10, ch2 01, ch3 00
    vecs[15] = '{1'b1, 1'b0, 1'b0, 8'b11111111, 4'b0011, 4'b0101, 4'b1011, 4'b0000, 4'b0111};
    // T with a=0101: ch0 and ch2 toggle
    vecs[16] = '{1'b1, 1'b0, 1'b0, 8'b10101010, 4'b0101, 4'b0000, 4'b1110, 4'b0000, 4'b0101};
    // ch0 SR 11 (flag only ch0), others D load 1
    vecs[17] = '{1'b1, 1'b0, 1'b0, 8'b01010100, 4'b1111, 4'b0001, 4'b1110, 4'b0001, 4'b0000};
    // err_clr acts even with en=0
    vecs[18] = '{1'b0, 1'b0, 1'b1, 8'b00000000, 4'b1111, 4'b1111, 4'b1110, 4'b0000, 4'b0000};

    bus.en      = 1'b0;
    bus.clr     = 1'b0;
    bus.err_clr = 1'b0;
    bus.mode    = '0;
    bus.a       = '0;
    bus.b       = '0;
    rst_n       = 1'b1;

    // Reset applied between edges must take effect without a clock.
    #7;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_async", RVAL, 4'b0000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'b11100100, 4'b1111, 4'b1111);
      checkOutput($sformatf("idle_hold_%0d", k), RVAL, 4'b0000, 4'b0000);
    end

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].en, vecs[i].clr, vecs[i].errClr, vecs[i].mode,
                    vecs[i].a, vecs[i].b);
      checkOutput($sformatf("vec_%0d", i), vecs[i].expQ, vecs[i].expErr,
                  vecs[i].expChg);
    end

    // Mid-operation reset. Starting from 1110, toggle twice. Then pull rst_n
    // low for half a period between edges.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'b11111111, 4'b1111, 4'b1111);
    checkOutput("run_tog_0", 4'b0001, 4'b0000, 4'b1111);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'b11111111, 4'b1111, 4'b1111);
    checkOutput("run_tog_1", 4'b1110, 4'b0000, 4'b1111);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset", RVAL, 4'b0000, 4'b0000);
    #5;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("resume_tog_0", 4'b1010, 4'b0000, 4'b1111);
    @(posedge clk);
    #1;
    checkOutput("resume_tog_1", 4'b0101, 4'b0000, 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
